// File: rtl/alu_exec_stage_if.sv
// Upstream operand/handshake bundle feeding the execute stage.
// master = issuing stage, slave = alu_exec_stage.
interface alu_exec_stage_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [AW-1:0]    rd;
  logic             rd_we;

  modport master (
    output in_valid, op, opa, opb, rd, rd_we,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, opa, opb, rd, rd_we,
    output in_ready
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops plus iterative shift-add MUL,
// writing back through the register-file write port.
module alu_exec_stage #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  alu_exec_stage_if.slave  up,
  output logic             wb_we,
  output logic [AW-1:0]    wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_c,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state, w_state_nxt;
  logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [AW-1:0]      r_rd, r_wb_reg;
  logic               r_rd_we, r_wb_we;
  logic [WIDTH-1:0]   r_wb_data;
  logic               r_z, r_c;

  logic               w_accept, w_last;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic [WIDTH:0]     w_sum, w_dif, w_shl, w_shr;

  assign up.in_ready = (r_state == S_IDLE) & ~reset;
  assign w_accept    = up.in_valid & up.in_ready;
  assign w_last      = (r_cnt == CW'(1));
  assign busy        = (r_state == S_MUL);
  assign wb_we       = r_wb_we;
  assign wb_reg      = r_wb_reg;
  assign wb_data     = r_wb_data;
  assign flag_z      = r_z;
  assign flag_c      = r_c;

  // Bit WIDTH of the shift-left and bit 0 of the shift-right hold the
  // last bit shifted out; both are 0 when the shift amount is 0.
  assign w_sum = {1'b0, up.opa} + {1'b0, up.opb};
  assign w_dif = {1'b0, up.opa} - {1'b0, up.opb};
  assign w_shl = {1'b0, up.opa} << up.opb[2:0];
  assign w_shr = {up.opa, 1'b0} >> up.opb[2:0];

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    unique case (up.op)
      3'd0: {w_c, w_res} = w_sum;
      3'd1: {w_c, w_res} = w_dif;
      3'd2: w_res = up.opa & up.opb;
      3'd3: w_res = up.opa | up.opb;
      3'd4: w_res = up.opa ^ up.opb;
      3'd5: {w_c, w_res} = w_shl;
      3'd6: {w_res, w_c} = w_shr;
      3'd7: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept && up.op == OP_MUL) w_state_nxt = S_MUL;
      S_MUL:  if (w_last) w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_reg  <= '0;
      r_wb_data <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wb_we <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept && up.op == OP_MUL) begin
          r_mcand  <= {{WIDTH{1'b0}}, up.opa};
          r_mplier <= up.opb;
          r_acc    <= '0;
          r_cnt    <= CW'(WIDTH);
          r_rd     <= up.rd;
          r_rd_we  <= up.rd_we;
        end else if (w_accept) begin
          r_wb_we   <= up.rd_we;
          r_wb_reg  <= up.rd;
          r_wb_data <= w_res;
          r_z       <= (w_res == '0);
          r_c       <= w_c;
        end
      end else begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
        if (w_last) begin
          r_wb_we   <= r_rd_we;
          r_wb_reg  <= r_rd;
          r_wb_data <= w_acc_nxt[WIDTH-1:0];
          r_z       <= (w_acc_nxt[WIDTH-1:0] == '0);
          r_c       <= |w_acc_nxt[2*WIDTH-1:WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed table, MUL/reset corner sequences
// and random ops against an arithmetic reference model.
module tb_alu_exec_stage;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wb_we, flag_z, flag_c, busy;
  logic [2:0] wb_reg;
  logic [7:0] wb_data;

  int n_chk = 0;
  int n_fail = 0;
  logic m_z = 1'b0;
  logic m_c = 1'b0;

  alu_exec_stage_if #(.WIDTH(8), .AW(3)) u_if ();

  alu_exec_stage #(.WIDTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .up(u_if.slave),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic [2:0] rd;
    logic       we;
    logic [7:0] d;
    logic       c, z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic void model(input logic [2:0] op,
                                input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic c);
    int ai, bi, sh, t;
    ai = a; bi = b; sh = bi % 8; t = 0; c = 1'b0;
    case (op)
      3'd0: begin t = ai + bi; c = (t > 255); end
      3'd1: begin t = ai - bi; c = (ai < bi); end
      3'd2: t = ai & bi;
      3'd3: t = ai | bi;
      3'd4: t = ai ^ bi;
      3'd5: begin
        t = ai * (1 << sh);
        c = (sh != 0) && (((ai >> (8 - sh)) & 1) == 1);
      end
      3'd6: begin
        t = ai / (1 << sh);
        c = (sh != 0) && (((ai >> (sh - 1)) & 1) == 1);
      end
      default: begin t = ai * bi; c = (t > 255); end
    endcase
    r = 8'(t & 255);
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] rd,
                       input logic we);
    u_if.in_valid = 1'b1;
    u_if.op = op; u_if.opa = a; u_if.opb = b;
    u_if.rd = rd; u_if.rd_we = we;
  endtask

  task automatic check_wb(input logic [2:0] rd, input logic we,
                          input logic [7:0] d, input logic c,
                          input logic z);
    chk("wb_we", wb_we, we);
    chk("wb_reg", wb_reg, rd);
    chk("wb_data", wb_data, d);
    chk("flag_c", flag_c, c);
    chk("flag_z", flag_z, z);
    m_c = c; m_z = z;
  endtask

  // Called at a negedge with the stage idle; returns at the negedge
  // where the result is visible, leaving in_valid asserted.
  task automatic apply(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] rd,
                       input logic we, input logic [7:0] d,
                       input logic c, input logic z);
    chk("in_ready_pre", u_if.in_ready, 1'b1);
    drive(op, a, b, rd, we);
    @(negedge clk);
    if (op == 3'd7) begin
      for (int i = 0; i < 8; i++) begin
        chk("mul_in_ready", u_if.in_ready, 1'b0);
        chk("mul_busy", busy, 1'b1);
        chk("mul_wb_we", wb_we, 1'b0);
        drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
              3'($urandom), 1'b1);
        @(negedge clk);
      end
      chk("mul_done_busy", busy, 1'b0);
    end
    check_wb(rd, we, d, c, z);
  endtask

  task automatic idle();
    u_if.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_wb_we", wb_we, 1'b0);
    chk("hold_c", flag_c, m_c);
    chk("hold_z", flag_z, m_z);
  endtask

  vec_t tbl[$];

  initial begin
    logic [7:0] r;
    logic       c;
    logic [2:0] op;
    logic [7:0] a, b;

    tbl = '{
      '{3'd0, 8'hF0, 8'h20, 3'd5, 1'b1, 8'h10, 1'b1, 1'b0},
      '{3'd1, 8'h05, 8'h05, 3'd1, 1'b1, 8'h00, 1'b0, 1'b1},
      '{3'd1, 8'h03, 8'h04, 3'd2, 1'b1, 8'hFF, 1'b1, 1'b0},
      '{3'd2, 8'hF0, 8'h3C, 3'd3, 1'b1, 8'h30, 1'b0, 1'b0},
      '{3'd3, 8'hF0, 8'h3C, 3'd4, 1'b1, 8'hFC, 1'b0, 1'b0},
      '{3'd4, 8'hF0, 8'h3C, 3'd6, 1'b1, 8'hCC, 1'b0, 1'b0},
      '{3'd5, 8'h81, 8'h01, 3'd7, 1'b1, 8'h02, 1'b1, 1'b0},
      '{3'd6, 8'h81, 8'h01, 3'd0, 1'b1, 8'h40, 1'b1, 1'b0},
      '{3'd5, 8'h81, 8'h00, 3'd1, 1'b1, 8'h81, 1'b0, 1'b0},
      '{3'd0, 8'h01, 8'hFF, 3'd2, 1'b0, 8'h00, 1'b1, 1'b1},
      '{3'd7, 8'h0F, 8'h11, 3'd3, 1'b1, 8'hFF, 1'b0, 1'b0},
      '{3'd7, 8'h10, 8'h10, 3'd4, 1'b1, 8'h00, 1'b1, 1'b1},
      '{3'd0, 8'h12, 8'h34, 3'd5, 1'b1, 8'h46, 1'b0, 1'b0}
    };

    u_if.in_valid = 1'b1;
    drive(3'd0, 8'h11, 8'h22, 3'd1, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_reg", wb_reg, 3'd0);
    chk("rst_wb_data", wb_data, 8'h00);
    chk("rst_z", flag_z, 1'b0);
    chk("rst_c", flag_c, 1'b0);
    chk("rst_busy", busy, 1'b0);
    u_if.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", u_if.in_ready, 1'b1);
    chk("rst_wb_we2", wb_we, 1'b0);

    // Back-to-back table; MUL rows also cover the held op after a stall.
    foreach (tbl[i])
      apply(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].we,
            tbl[i].d, tbl[i].c, tbl[i].z);
    idle();
    idle();

    // Reset during MUL iteration 3.
    apply(3'd0, 8'hFF, 8'h01, 3'd1, 1'b1, 8'h00, 1'b1, 1'b1);
    drive(3'd7, 8'hFF, 8'hFF, 3'd6, 1'b1);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_c", flag_c, 1'b0);
    chk("mid_z", flag_z, 1'b0);
    chk("mid_wb_we", wb_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_c = 1'b0; m_z = 1'b0;
    for (int i = 0; i < 10; i++) idle();
    chk("mid_in_ready", u_if.in_ready, 1'b1);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      model(op, a, b, r, c);
      apply(op, a, b, 3'($urandom), 1'($urandom), r, c, (r == 8'h00));
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
